// File: rtl/key_input_pkg.sv
// ---------------------------------------------------------------------------
// key_input_pkg
// Shared types and constants for the push-button input path.
//   key_state_t      : per-channel debounce FSM state
//   KEY_ACTIVE_LEVEL : pin level that means "button pressed" (buttons are active-low)
// ---------------------------------------------------------------------------
package key_input_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam logic KEY_ACTIVE_LEVEL = 1'b0;

endpackage : key_input_pkg

// File: rtl/key_debounce_ch.sv
// ---------------------------------------------------------------------------
// key_debounce_ch
// One debounced key channel: 2-flop synchronizer, 4-state debounce FSM,
// stability counter and registered level/pulse outputs.
// Optional auto-repeat of key_press while held: define KEY_REPEAT_EN.
// Ports:
//   clk          in   system clock
//   resetn       in   asynchronous active-low reset
//   key_n        in   raw button pin, 0 = pressed, asynchronous to clk
//   key_level    out  debounced state, 1 = pressed
//   key_press    out  one-cycle pulse on accepted press (and each auto-repeat)
//   key_release  out  one-cycle pulse on accepted release
// ---------------------------------------------------------------------------
module key_debounce_ch
  import key_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd500000
`ifdef KEY_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 32'd25000000,
  parameter int unsigned REPEAT_PERIOD   = 32'd5000000
`endif
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic             sync1_q;
  logic             sync2_q;
  key_state_t       state_q;
  key_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             press_q;
  logic             press_d;
  logic             release_q;
  logic             release_d;
  logic             active_s;

`ifdef KEY_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = (RPT_MAX > 32'd1) ? $clog2(RPT_MAX) : 32'd1;
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 32'd1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 32'd1);

  logic [RPT_W-1:0] rpt_cnt_q;
  logic [RPT_W-1:0] rpt_cnt_d;
  logic [RPT_W-1:0] rpt_limit_s;
  // Set on acceptance so the first repeat uses the longer initial delay.
  logic             rpt_first_q;
  logic             rpt_first_d;
`endif

  assign active_s = (sync2_q == KEY_ACTIVE_LEVEL);

  // Two-flop synchronizer; idles at the released pin level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  // FSM state, stability counter and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= RELEASED;
      cnt_q     <= {CNT_W{1'b0}};
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef KEY_REPEAT_EN
  // Auto-repeat counter; only advances while settled in PRESSED.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rpt_cnt_q   <= {RPT_W{1'b0}};
      rpt_first_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`endif

  // Next-state, counter and output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef KEY_REPEAT_EN
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    rpt_limit_s = rpt_first_q ? RPT_DELAY_LAST : RPT_PERIOD_LAST;
`endif

    case (state_q)
      RELEASED: begin
        if (active_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d   = {CNT_W{1'b0}};
        end
      end

      PRESS_WAIT: begin
        if (!active_s) begin
          state_d = RELEASED;
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
          // Counter stops at CNT_LAST, so it can never wrap.
          state_d = PRESSED;
          cnt_d   = {CNT_W{1'b0}};
          level_d = 1'b1;
          press_d = 1'b1;
`ifdef KEY_REPEAT_EN
          rpt_cnt_d   = {RPT_W{1'b0}};
          rpt_first_d = 1'b1;
`endif
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      PRESSED: begin
        if (!active_s) begin
          // Repeat counter is left untouched so a bounce back resumes it.
          state_d = RELEASE_WAIT;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
`ifdef KEY_REPEAT_EN
          if (rpt_cnt_q == rpt_limit_s) begin
            press_d     = 1'b1;
            rpt_cnt_d   = {RPT_W{1'b0}};
            rpt_first_d = 1'b0;
          end else begin
            rpt_cnt_d   = rpt_cnt_q + RPT_W'(1);
          end
`else
          state_d = PRESSED;
`endif
        end
      end

      RELEASE_WAIT: begin
        if (active_s) begin
          state_d = PRESSED;
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RELEASED;
          cnt_d     = {CNT_W{1'b0}};
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = RELEASED;
        cnt_d   = {CNT_W{1'b0}};
        level_d = 1'b0;
      end
    endcase
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule : key_debounce_ch

// File: rtl/key_debouncer.sv
// ---------------------------------------------------------------------------
// key_debouncer
// Conditions N_KEYS raw active-low push-buttons into clean clock-synchronous
// levels and one-cycle press/release pulses. Each key is an independent
// key_debounce_ch instance.
// Optional feature macro: KEY_REPEAT_EN enables auto-repeat of key_press
// (REPEAT_DELAY cycles after acceptance, then every REPEAT_PERIOD cycles).
// Ports:
//   clk          in   system clock
//   resetn       in   asynchronous active-low reset
//   key_n        in   [N_KEYS] raw pins, 0 = pressed, asynchronous to clk
//   key_level    out  [N_KEYS] debounced state, 1 = pressed
//   key_press    out  [N_KEYS] one-cycle pulse on accepted press / auto-repeat
//   key_release  out  [N_KEYS] one-cycle pulse on accepted release
// ---------------------------------------------------------------------------
module key_debouncer
  import key_input_pkg::*;
#(
  parameter int unsigned N_KEYS          = 32'd4,
  parameter int unsigned DEBOUNCE_CYCLES = 32'd500000,
  parameter int unsigned REPEAT_DELAY    = 32'd25000000,
  parameter int unsigned REPEAT_PERIOD   = 32'd5000000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  // Reject configurations the channel counters cannot represent.
  if ((DEBOUNCE_CYCLES < 32'd2) || (REPEAT_DELAY < 32'd1) || (REPEAT_PERIOD < 32'd1)) begin : g_param_check
    $error("key_debouncer: DEBOUNCE_CYCLES must be >= 2 and REPEAT_* >= 1");
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEY_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk         (clk),
      .resetn      (resetn),
      .key_n       (key_n[g]),
      .key_level   (key_level[g]),
      .key_press   (key_press[g]),
      .key_release (key_release[g])
    );
  end

endmodule : key_debouncer

// File: tb/tb_key_debouncer.sv
// ---------------------------------------------------------------------------
// tb_key_debouncer
// Self-checking bench for key_debouncer (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3). The reference model describes each key as "the debounced
// level flips once the synchronized pin has disagreed with it for
// DEBOUNCE_CYCLES+1 consecutive clock edges", plus a held-time counter for
// auto-repeat when KEY_REPEAT_EN is defined.
// ---------------------------------------------------------------------------
module tb_key_debouncer;

  localparam int NK = 4;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic [NK-1:0] key_n;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [NK-1:0] m_r1, m_r2;
  logic [NK-1:0] m_lvl, m_press, m_rel;
  int            m_run     [NK];
  int            m_elapsed [NK];
  bit            m_first   [NK];

  key_debouncer #(
    .N_KEYS          (NK),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .key_n       (key_n),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_r1 = '1; m_r2 = '1;
    m_lvl = '0; m_press = '0; m_rel = '0;
    for (int k = 0; k < NK; k++) begin
      m_run[k] = 0; m_elapsed[k] = 0; m_first[k] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [NK-1:0] raw);
    for (int k = 0; k < NK; k++) begin
      automatic bit sp = (m_r2[k] == 1'b0);   // pin value two edges ago, as "pressed"
      m_r2[k] = m_r1[k];
      m_r1[k] = raw[k];
      m_press[k] = 1'b0;
      m_rel[k]   = 1'b0;
      if (sp != m_lvl[k]) begin
        m_run[k]++;
        if (m_run[k] == D + 1) begin
          m_lvl[k] = sp;
          m_run[k] = 0;
          if (sp) begin
            m_press[k] = 1'b1; m_elapsed[k] = 0; m_first[k] = 1'b1;
          end else begin
            m_rel[k] = 1'b1;
          end
        end
      end else begin
`ifdef KEY_REPEAT_EN
        if (m_lvl[k] && m_run[k] == 0) begin
          m_elapsed[k]++;
          if (m_elapsed[k] == (m_first[k] ? RD : RP)) begin
            m_press[k] = 1'b1; m_elapsed[k] = 0; m_first[k] = 1'b0;
          end
        end
`endif
        m_run[k] = 0;
      end
    end
  endtask

  // One clock: advance the model at the rising edge, return at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!resetn) model_reset();
    else model_edge(key_n);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int first_seen = -1;
    resetn = 1'b0;
    key_n  = 4'b0000;
    model_reset();
    #1;
    checks++;
    if ({key_level, key_press, key_release} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs got lvl=%b prs=%b rel=%b want all 0", key_level, key_press, key_release);
    end
    @(negedge clk);
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++;
      if ({key_level, key_press, key_release} !== {m_lvl, m_press, m_rel}) begin
        failures++;
        $display("FAIL reset_hold t=%0d got %b/%b/%b want %b/%b/%b", t, key_level, key_press, key_release, m_lvl, m_press, m_rel);
      end
    end
    resetn = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      checks++;
      if ({key_level, key_press, key_release} !== {m_lvl, m_press, m_rel}) begin
        failures++;
        $display("FAIL reset_release t=%0d got %b/%b/%b want %b/%b/%b", t, key_level, key_press, key_release, m_lvl, m_press, m_rel);
      end
      if (key_press == 4'b1111 && first_seen < 0) first_seen = t;
    end
    checks++;
    if (first_seen != D + 3) begin
      failures++;
      $display("FAIL reset_accept_latency got tick %0d want %0d", first_seen, D + 3);
    end
    checks++;
    if (key_level !== 4'b1111) begin
      failures++;
      $display("FAIL reset_accept_level got %b want 1111", key_level);
    end
  endtask

  task automatic test_clean_press();
    int t_press = -1, t_rel = -1;
    for (int t = 0; t < 44; t++) begin
      key_n = 4'hF;
      if (t >= 14 && t < 22) key_n[0] = 1'b0;   // press at tick 14, release at tick 22
      tick();
      checks++;
      if ({key_level, key_press, key_release} !== {m_lvl, m_press, m_rel}) begin
        failures++;
        $display("FAIL clean_press t=%0d got %b/%b/%b want %b/%b/%b", t, key_level, key_press, key_release, m_lvl, m_press, m_rel);
      end
      if (t >= 14 && key_press[0] && t_press < 0) t_press = t;
      if (t >= 22 && key_release[0] && t_rel < 0) t_rel = t;
    end
    checks++;
    if (t_press != 14 + D + 2 || t_rel != 22 + D + 2) begin
      failures++;
      $display("FAIL clean_latency got press=%0d release=%0d want %0d %0d", t_press, t_rel, 14 + D + 2, 22 + D + 2);
    end
    checks++;
    if (key_level !== 4'b0000) begin
      failures++;
      $display("FAIL clean_final_level got %b want 0000", key_level);
    end
  endtask

  task automatic test_bounce();
    int bounce_pulses = 0, pulses = 0, t_press = -1;
    key_n = 4'hF;
    for (int t = 0; t < 40; t++) begin
      if (t < 20 && (t % 2) == 0) key_n[1] = ~key_n[1];
      if (t == 20) key_n[1] = 1'b0;            // final edge, then held
      tick();
      checks++;
      if ({key_level, key_press, key_release} !== {m_lvl, m_press, m_rel}) begin
        failures++;
        $display("FAIL bounce t=%0d got %b/%b/%b want %b/%b/%b", t, key_level, key_press, key_release, m_lvl, m_press, m_rel);
      end
      if (t < 20 && key_press[1]) bounce_pulses++;
      if (t >= 20 && key_press[1]) begin
        pulses++;
        if (t_press < 0) t_press = t;
      end
    end
    checks++;
    if (bounce_pulses != 0 || t_press != 20 + D + 2) begin
      failures++;
      $display("FAIL bounce_accept got bounce_pulses=%0d press_tick=%0d want 0 %0d", bounce_pulses, t_press, 20 + D + 2);
    end
`ifndef KEY_REPEAT_EN
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL bounce_single got %0d pulses want 1", pulses);
    end
`endif
    key_n = 4'hF;
  endtask

  task automatic test_glitch();
    int pulses = 0, lvl_seen = 0;
    key_n = 4'hF;
    for (int t = 0; t < 30; t++) begin
      key_n[1] = 1'b1;
      key_n[2] = (t >= 12 && t < 15) ? 1'b0 : 1'b1;   // 3-cycle glitch
      tick();
      checks++;
      if ({key_level, key_press, key_release} !== {m_lvl, m_press, m_rel}) begin
        failures++;
        $display("FAIL glitch t=%0d got %b/%b/%b want %b/%b/%b", t, key_level, key_press, key_release, m_lvl, m_press, m_rel);
      end
      checks++;
      if ((key_press & key_release) !== 4'b0000) begin
        failures++;
        $display("FAIL press_release_overlap got %b want 0000", key_press & key_release);
      end
      if (t >= 12) begin
        if (key_press[2] || key_release[2]) pulses++;
        if (key_level[2]) lvl_seen++;
      end
    end
    checks++;
    if (pulses != 0 || lvl_seen != 0) begin
      failures++;
      $display("FAIL glitch_suppress got pulses=%0d level_hi=%0d want 0 0", pulses, lvl_seen);
    end
  endtask

  task automatic test_reset_mid_wait();
    int t_press = -1, early = 0;
    key_n = 4'hF;
    key_n[3] = 1'b0;
    for (int t = 0; t < 4; t++) begin        // PRESS_WAIT entered at 3rd edge, 2 cycles in
      tick();
      if (key_press[3]) early++;
    end
    resetn = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({key_level, key_press, key_release} !== 12'h000 || early != 0) begin
      failures++;
      $display("FAIL reset_mid_wait got %b/%b/%b early=%0d want 0/0/0 0", key_level, key_press, key_release, early);
    end
    @(negedge clk);
    tick();
    resetn = 1'b1;
    for (int t = 0; t < 12; t++) begin
      tick();
      checks++;
      if ({key_level, key_press, key_release} !== {m_lvl, m_press, m_rel}) begin
        failures++;
        $display("FAIL reset_mid_wait_after t=%0d got %b/%b/%b want %b/%b/%b", t, key_level, key_press, key_release, m_lvl, m_press, m_rel);
      end
      if (key_press[3] && t_press < 0) t_press = t;
    end
    checks++;
    if (t_press != D + 2) begin
      failures++;
      $display("FAIL reset_mid_wait_latency got tick %0d want %0d", t_press, D + 2);
    end
    key_n = 4'hF;
  endtask

  task automatic test_repeat();
    int pt[$];
    for (int t = 0; t < 60; t++) begin
      key_n = 4'hF;
      if (t >= 12 && t < 42) key_n[3] = 1'b0;   // held 30 cycles
      tick();
      checks++;
      if ({key_level, key_press, key_release} !== {m_lvl, m_press, m_rel}) begin
        failures++;
        $display("FAIL repeat t=%0d got %b/%b/%b want %b/%b/%b", t, key_level, key_press, key_release, m_lvl, m_press, m_rel);
      end
      if (t >= 12 && key_press[3]) pt.push_back(t);
    end
`ifdef KEY_REPEAT_EN
    checks++;
    if (pt.size() != 7 || pt[0] != 18 || pt[1] != 28 || pt[2] != 31 || pt[3] != 34) begin
      failures++;
      $display("FAIL repeat_schedule got count=%0d first=%0d want 7 pulses at 18,28,31,34,...", pt.size(), (pt.size() > 0) ? pt[0] : -1);
    end
`else
    checks++;
    if (pt.size() != 1 || pt[0] != 18) begin
      failures++;
      $display("FAIL repeat_single got count=%0d want 1 pulse at 18", pt.size());
    end
`endif
  endtask

  task automatic test_random();
    int hold [NK];
    for (int k = 0; k < NK; k++) hold[k] = $urandom_range(1, 9);
    for (int t = 0; t < 800; t++) begin
      for (int k = 0; k < NK; k++) begin
        hold[k]--;
        if (hold[k] <= 0) begin
          key_n[k] = ~key_n[k];
          hold[k]  = $urandom_range(1, 9);
        end
      end
      if (resetn && $urandom_range(0, 199) == 0) resetn = 1'b0;
      else resetn = 1'b1;
      tick();
      checks++;
      if ({key_level, key_press, key_release} !== {m_lvl, m_press, m_rel}) begin
        failures++;
        $display("FAIL random t=%0d got %b/%b/%b want %b/%b/%b", t, key_level, key_press, key_release, m_lvl, m_press, m_rel);
      end
    end
    resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_reset_mid_wait();
    test_repeat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_key_debouncer
